// File: rtl/alu_cmd_master_pkg.sv
// Shared types and widths for the ALU command master and its result mux.
package alu_cmd_pkg;
   localparam int OP_W   = 16;
   localparam int RES_W  = 32;
   localparam int FUNC_W = 4;
   localparam int CMP_W  = 3;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   typedef enum logic [1:0] {ARITH = 2'b00, LOGIC = 2'b01, CMP = 2'b10, SHIFT = 2'b11} class_t;

   function automatic class_t func_class(input logic [FUNC_W-1:0] f);
      return class_t'(f[3:2]);
   endfunction
endpackage

// File: rtl/alu_cmd_master_if.sv
// Request, ALU operand/result and response signals of the command master.
interface alu_cmd_master_if;
   import alu_cmd_pkg::*;

   logic              req_valid;
   logic              req_ready;
   logic [OP_W-1:0]   req_a;
   logic [OP_W-1:0]   req_b;
   logic [FUNC_W-1:0] req_func;
   logic [OP_W-1:0]   A;
   logic [OP_W-1:0]   B;
   logic [FUNC_W-1:0] ALU_FUNC;
   logic [RES_W-1:0]  Arith_OUT;
   logic [OP_W-1:0]   Logic_OUT;
   logic [OP_W-1:0]   Shift_OUT;
   logic [CMP_W-1:0]  CMP_OUT;
   logic              Carry_OUT;
   logic              Arith_Flag;
   logic              Logic_Flag;
   logic              Shift_Flag;
   logic              CMP_Flag;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [RES_W-1:0]  rsp_data;
   logic              rsp_carry;
   logic [1:0]        rsp_class;
   logic              rsp_err;

   modport master (
      input  req_valid, req_a, req_b, req_func,
      output req_ready, A, B, ALU_FUNC,
      input  Arith_OUT, Logic_OUT, Shift_OUT, CMP_OUT, Carry_OUT,
      input  Arith_Flag, Logic_Flag, Shift_Flag, CMP_Flag,
      output rsp_valid, rsp_data, rsp_carry, rsp_class, rsp_err,
      input  rsp_ready
   );

   modport slave (
      output req_valid, req_a, req_b, req_func,
      input  req_ready, A, B, ALU_FUNC,
      output Arith_OUT, Logic_OUT, Shift_OUT, CMP_OUT, Carry_OUT,
      output Arith_Flag, Logic_Flag, Shift_Flag, CMP_Flag,
      input  rsp_valid, rsp_data, rsp_carry, rsp_class, rsp_err,
      output rsp_ready
   );
endinterface

// File: rtl/alu_cmd_master_result_mux.sv
// Selects and zero-extends the result for the command's class and decodes
// whether the matching flag or some other class flag is raised.
module alu_result_mux
   import alu_cmd_pkg::*;
(
   input  class_t             i_cls,
   input  logic [RES_W-1:0]   i_arith,
   input  logic [OP_W-1:0]    i_logic,
   input  logic [OP_W-1:0]    i_shift,
   input  logic [CMP_W-1:0]   i_cmp,
   input  logic               i_carry,
   input  logic               i_arith_flag,
   input  logic               i_logic_flag,
   input  logic               i_shift_flag,
   input  logic               i_cmp_flag,
   output logic [RES_W-1:0]   o_data,
   output logic               o_carry,
   output logic               o_exp_flag,
   output logic               o_wrong_flag
);
   always_comb begin
      o_data     = '0;
      o_carry    = 1'b0;
      o_exp_flag = 1'b0;
      unique case (i_cls)
         ARITH: begin
            o_data     = i_arith;
            o_carry    = i_carry;
            o_exp_flag = i_arith_flag;
         end
         LOGIC: begin
            o_data     = {{(RES_W-OP_W){1'b0}}, i_logic};
            o_exp_flag = i_logic_flag;
         end
         CMP: begin
            o_data     = {{(RES_W-CMP_W){1'b0}}, i_cmp};
            o_exp_flag = i_cmp_flag;
         end
         SHIFT: begin
            o_data     = {{(RES_W-OP_W){1'b0}}, i_shift};
            o_exp_flag = i_shift_flag;
         end
      endcase
   end

   // Only meaningful when the expected flag is low; expected always wins.
   assign o_wrong_flag = (i_arith_flag | i_logic_flag | i_shift_flag | i_cmp_flag) & ~o_exp_flag;
endmodule

// File: rtl/alu_cmd_master.sv
// Single-outstanding ALU command initiator: issue operands, wait for the
// class flag (or time out), return a normalised result on a valid/ready channel.
module alu_cmd_master
   import alu_cmd_pkg::*;
#(
   parameter int TIMEOUT = 8,
   parameter int CNT_W   = 4
)(
   input logic               CLK,
   input logic               RST,
   alu_cmd_master_if.master  bus
);
   state_t             r_state, w_nstate;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic [OP_W-1:0]    r_a, r_b;
   logic [FUNC_W-1:0]  r_func;
   logic               r_req_ready;
   logic               r_rsp_valid;
   logic [RES_W-1:0]   r_rsp_data;
   logic               r_rsp_carry;
   logic [1:0]         r_rsp_class;
   logic               r_rsp_err;

   class_t             w_cls;
   logic [RES_W-1:0]   w_data;
   logic               w_carry, w_exp, w_wrong;
   logic               w_accept, w_rsp_hs, w_capture;

   assign w_cls     = func_class(r_func);
   assign w_accept  = bus.req_valid & r_req_ready;
   assign w_rsp_hs  = r_rsp_valid & bus.rsp_ready;
   assign w_capture = (r_state == WAIT) & (w_nstate == RESP);

   alu_result_mux u_mux (
      .i_cls        (w_cls),
      .i_arith      (bus.Arith_OUT),
      .i_logic      (bus.Logic_OUT),
      .i_shift      (bus.Shift_OUT),
      .i_cmp        (bus.CMP_OUT),
      .i_carry      (bus.Carry_OUT),
      .i_arith_flag (bus.Arith_Flag),
      .i_logic_flag (bus.Logic_Flag),
      .i_shift_flag (bus.Shift_Flag),
      .i_cmp_flag   (bus.CMP_Flag),
      .o_data       (w_data),
      .o_carry      (w_carry),
      .o_exp_flag   (w_exp),
      .o_wrong_flag (w_wrong)
   );

   always_comb begin
      w_nstate  = r_state;
      w_cnt_nxt = r_cnt;
      case (r_state)
         IDLE:  if (w_accept) w_nstate = ISSUE;
         ISSUE: begin
            // ALU is still registering the new operands; flags are stale here.
            w_cnt_nxt = '0;
            w_nstate  = WAIT;
         end
         WAIT: begin
            if (w_exp || w_wrong)                     w_nstate  = RESP;
            else if (r_cnt == CNT_W'(TIMEOUT - 1))    w_nstate  = RESP;
            else if (r_cnt != {CNT_W{1'b1}})          w_cnt_nxt = r_cnt + 1'b1;
         end
         RESP:  if (w_rsp_hs) w_nstate = IDLE;
         default: w_nstate = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_func      <= '0;
         r_req_ready <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_carry <= 1'b0;
         r_rsp_class <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_state     <= w_nstate;
         r_cnt       <= w_cnt_nxt;
         r_req_ready <= (w_nstate == IDLE);
         r_rsp_valid <= (w_nstate == RESP);
         if (w_accept) begin
            r_a    <= bus.req_a;
            r_b    <= bus.req_b;
            r_func <= bus.req_func;
         end
         if (w_capture) begin
            r_rsp_data  <= w_exp ? w_data  : '0;
            r_rsp_carry <= w_exp ? w_carry : 1'b0;
            r_rsp_class <= w_cls;
            r_rsp_err   <= ~w_exp;
         end
      end
   end

   assign bus.req_ready = r_req_ready;
   assign bus.A         = r_a;
   assign bus.B         = r_b;
   assign bus.ALU_FUNC  = r_func;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_data  = r_rsp_data;
   assign bus.rsp_carry = r_rsp_carry;
   assign bus.rsp_class = r_rsp_class;
   assign bus.rsp_err   = r_rsp_err;
endmodule

// File: tb/tb_alu_cmd_master.sv
// Scoreboard bench: directed commands push expected responses; a negedge
// monitor pops and compares every response handshake.
module tb_alu_cmd_master;
   localparam int MD_OK = 0, MD_NONE = 1, MD_WRONG = 2, MD_ALL = 3;

   typedef struct {
      logic [31:0] data;
      logic        carry;
      logic [1:0]  cls;
      logic        err;
      int          lat;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0, nvec = 0, nmis = 0, mode = MD_OK, last_hs = 0;
   exp_t q[$];

   alu_cmd_master_if bus();

   alu_cmd_master #(.TIMEOUT(8), .CNT_W(4)) dut (
      .CLK (clk),
      .RST (rst_n),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural 1-cycle ALU
   function automatic logic [31:0] ar_f(input logic [15:0] a, b, input logic [1:0] op);
      case (op)
         2'd0:    return {16'h0, a} + {16'h0, b};
         2'd1:    return {16'h0, a} - {16'h0, b};
         2'd2:    return {16'h0, a} * {16'h0, b};
         default: return (b != 16'h0) ? {16'h0, a / b} : 32'h0;
      endcase
   endfunction

   function automatic logic [15:0] lg_f(input logic [15:0] a, b, input logic [1:0] op);
      case (op)
         2'd0:    return a & b;
         2'd1:    return a | b;
         2'd2:    return a ^ b;
         default: return ~(a | b);
      endcase
   endfunction

   function automatic logic [15:0] sh_f(input logic [15:0] a, b, input logic [1:0] op);
      case (op)
         2'd0:    return a >> 1;
         2'd1:    return a << 1;
         2'd2:    return a >> b[3:0];
         default: return a << b[3:0];
      endcase
   endfunction

   function automatic logic [2:0] cmp_f(input logic [15:0] a, b, input logic [1:0] op);
      case (op)
         2'd0:    return {2'b00, a == b};
         2'd1:    return {1'b0, a > b, 1'b0};
         2'd2:    return {a < b, 2'b00};
         default: return 3'b000;
      endcase
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         bus.Arith_OUT  <= '0;
         bus.Logic_OUT  <= '0;
         bus.Shift_OUT  <= '0;
         bus.CMP_OUT    <= '0;
         bus.Carry_OUT  <= 1'b0;
         bus.Arith_Flag <= 1'b0;
         bus.Logic_Flag <= 1'b0;
         bus.Shift_Flag <= 1'b0;
         bus.CMP_Flag   <= 1'b0;
      end else begin
         bus.Arith_OUT  <= ar_f(bus.A, bus.B, bus.ALU_FUNC[1:0]);
         bus.Carry_OUT  <= (bus.ALU_FUNC[1:0] == 2'd0) & ar_f(bus.A, bus.B, 2'd0) >> 16 != 0;
         bus.Logic_OUT  <= lg_f(bus.A, bus.B, bus.ALU_FUNC[1:0]);
         bus.Shift_OUT  <= sh_f(bus.A, bus.B, bus.ALU_FUNC[1:0]);
         bus.CMP_OUT    <= cmp_f(bus.A, bus.B, bus.ALU_FUNC[1:0]);
         bus.Arith_Flag <= (mode == MD_ALL) || (mode == MD_OK && bus.ALU_FUNC[3:2] == 2'b00);
         bus.Logic_Flag <= (mode == MD_ALL) || (mode == MD_WRONG) ||
                           (mode == MD_OK && bus.ALU_FUNC[3:2] == 2'b01);
         bus.CMP_Flag   <= (mode == MD_ALL) || (mode == MD_OK && bus.ALU_FUNC[3:2] == 2'b10);
         bus.Shift_Flag <= (mode == MD_ALL) || (mode == MD_OK && bus.ALU_FUNC[3:2] == 2'b11);
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Monitor / scoreboard
   initial begin
      exp_t        e;
      bit          seen;
      int          acc, lat;
      logic [31:0] prv_data;
      logic        prv_err;
      seen = 0; acc = 0; lat = 0; prv_data = '0; prv_err = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) seen = 0;
         else begin
            if (bus.req_valid && bus.req_ready) acc = cyc + 1;
            if (bus.rsp_valid) begin
               chk("rsp_req_ready_low", 32'(bus.req_ready), 32'd0);
               if (!seen) begin
                  seen     = 1;
                  lat      = cyc - acc;
                  prv_data = bus.rsp_data;
                  prv_err  = bus.rsp_err;
               end else begin
                  chk("stall_data_stable", bus.rsp_data, prv_data);
                  chk("stall_err_stable", 32'(bus.rsp_err), 32'(prv_err));
               end
               if (bus.rsp_ready) begin
                  last_hs = cyc + 1;
                  seen    = 0;
                  if (q.size() == 0) begin
                     nvec++; nmis++;
                     $display("FAIL unexpected_rsp: got data %0h want no response", bus.rsp_data);
                  end else begin
                     e = q.pop_front();
                     chk("rsp_data",  bus.rsp_data,          e.data);
                     chk("rsp_carry", 32'(bus.rsp_carry),    32'(e.carry));
                     chk("rsp_class", 32'(bus.rsp_class),    32'(e.cls));
                     chk("rsp_err",   32'(bus.rsp_err),      32'(e.err));
                     chk("rsp_lat",   32'(lat),              32'(e.lat));
                  end
               end
            end
         end
      end
   end

   task automatic send(input logic [15:0] a, b, input logic [3:0] f, input int md,
                       input bit push, input exp_t e, output int acc);
      int n;
      bus.req_a = a; bus.req_b = b; bus.req_func = f; bus.req_valid = 1'b1;
      n = 0; acc = -1;
      @(negedge clk);
      while (!bus.req_ready && n < 100) begin @(negedge clk); n++; end
      if (!bus.req_ready) begin
         nvec++; nmis++;
         $display("FAIL accept_timeout: req_ready 0 want 1");
      end else begin
         mode = md;
         if (push) q.push_back(e);
         acc = cyc + 1;
      end
      @(posedge clk); #2 bus.req_valid = 1'b0;
   endtask

   task automatic run(input logic [15:0] a, b, input logic [3:0] f, input int md,
                      input logic [31:0] d, input logic c, input logic [1:0] cl,
                      input logic er, input int lt);
      exp_t e;
      int   acc;
      e.data = d; e.carry = c; e.cls = cl; e.err = er; e.lat = lt;
      send(a, b, f, md, 1'b1, e, acc);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 100) begin @(negedge clk); n++; end
      chk("drain_queue_empty", 32'(q.size()), 32'd0);
      @(posedge clk); #2;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      int   acc;
      bus.req_valid = 1'b0; bus.req_a = '0; bus.req_b = '0; bus.req_func = '0;
      bus.rsp_ready = 1'b1;
      e.data = '0; e.carry = 1'b0; e.cls = '0; e.err = 1'b0; e.lat = 0;

      #1;
      chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_A",         32'(bus.A),         32'd0);
      chk("rst_ALU_FUNC",  32'(bus.ALU_FUNC),  32'd0);
      chk("rst_rsp_data",  bus.rsp_data,       32'd0);
      chk("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk); chk("rdy_before_edge", 32'(bus.req_ready), 32'd0);
      @(negedge clk); chk("rdy_after_edge",  32'(bus.req_ready), 32'd1);
      @(posedge clk); #2;

      //    a         b         func   mode      data          c     cls    err   lat
      run(16'h0005, 16'h0003, 4'h0, MD_OK,    32'h0000_0008, 1'b0, 2'd0, 1'b0, 2);
      run(16'hFFFF, 16'h0002, 4'h2, MD_OK,    32'h0001_FFFE, 1'b0, 2'd0, 1'b0, 2);
      run(16'hFFFF, 16'h0001, 4'h0, MD_OK,    32'h0001_0000, 1'b1, 2'd0, 1'b0, 2);
      run(16'h0009, 16'h0004, 4'h9, MD_OK,    32'h0000_0002, 1'b0, 2'd2, 1'b0, 2);
      run(16'hF0F0, 16'hFF00, 4'h4, MD_OK,    32'h0000_F000, 1'b0, 2'd1, 1'b0, 2);
      run(16'h8001, 16'h0000, 4'hD, MD_OK,    32'h0000_0002, 1'b0, 2'd3, 1'b0, 2);
      run(16'h0005, 16'h0003, 4'h0, MD_NONE,  32'h0000_0000, 1'b0, 2'd0, 1'b1, 9);
      run(16'h0005, 16'h0003, 4'h0, MD_WRONG, 32'h0000_0000, 1'b0, 2'd0, 1'b1, 2);
      run(16'h0005, 16'h0003, 4'h0, MD_ALL,   32'h0000_0008, 1'b0, 2'd0, 1'b0, 2);
      run(16'h1234, 16'h00FF, 4'h5, MD_NONE,  32'h0000_0000, 1'b0, 2'd1, 1'b1, 9);
      drain();

      // Response stall with a second command waiting behind it
      bus.rsp_ready = 1'b0;
      run(16'h1234, 16'h00FF, 4'h5, MD_OK, 32'h0000_12FF, 1'b0, 2'd1, 1'b0, 2);
      fork
         begin
            int k;
            k = 0;
            while (!bus.rsp_valid && k < 50) begin @(negedge clk); k++; end
            repeat (5) @(posedge clk);
            #2 bus.rsp_ready = 1'b1;
         end
      join_none
      e.data = 32'h0000_0007; e.carry = 1'b0; e.cls = 2'd0; e.err = 1'b0; e.lat = 2;
      send(16'h000A, 16'h0003, 4'h1, MD_OK, 1'b1, e, acc);
      chk("accept_after_hs", 32'(acc - last_hs), 32'd1);
      drain();

      // Reset while waiting on a result
      send(16'h0005, 16'h0003, 4'h0, MD_NONE, 1'b0, e, acc);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("midrst_A",         32'(bus.A),         32'd0);
      chk("midrst_B",         32'(bus.B),         32'd0);
      chk("midrst_ALU_FUNC",  32'(bus.ALU_FUNC),  32'd0);
      chk("midrst_req_ready", 32'(bus.req_ready), 32'd0);
      @(posedge clk); #2 rst_n = 1'b1;
      run(16'h0005, 16'h0003, 4'h0, MD_OK, 32'h0000_0008, 1'b0, 2'd0, 1'b0, 2);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end
endmodule
